// File: rtl/osc_bank_if.sv
// osc_bank_if
//   Bus between the oscillator bank and its controller/mixer.
//   master : drives tick and the channel config write port, receives the
//            sample stream (busy, out, out_ch, out_valid).
//   slave  : the oscillator bank itself.
//   Parameters must match the osc_bank instance they connect to.
interface osc_bank_if #(
    parameter int BITDEPTH = 14,
    parameter int CHANNELS = 4
);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                tick;
    logic                cfg_we;
    logic [CHW-1:0]      cfg_ch;
    logic [15:0]         cfg_inc;
    logic [2:0]          cfg_wave;
    logic [BITDEPTH-1:0] cfg_pw;
    logic                cfg_phase_rst;
    logic                busy;
    logic [BITDEPTH-1:0] out;
    logic [CHW-1:0]      out_ch;
    logic                out_valid;

    modport master (
        output tick, cfg_we, cfg_ch, cfg_inc, cfg_wave, cfg_pw, cfg_phase_rst,
        input  busy, out, out_ch, out_valid
    );

    modport slave (
        input  tick, cfg_we, cfg_ch, cfg_inc, cfg_wave, cfg_pw, cfg_phase_rst,
        output busy, out, out_ch, out_valid
    );
endinterface

// File: rtl/osc_bank.sv
// osc_bank
//   Time-multiplexed bank of CHANNELS phase-accumulator oscillators. A tick
//   starts a sweep; one shared datapath advances one channel per clock and
//   streams the resulting sample with its channel index and a valid strobe.
// Ports
//   sample_clock : sole clock, rising edge
//   rst          : asynchronous, active-high reset
//   bus          : osc_bank_if.slave (tick, config write port, sample stream)
module osc_bank #(
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 6,
    parameter int CHANNELS    = 4
) (
    input  logic      sample_clock,
    input  logic      rst,
    osc_bank_if.slave bus
);
    localparam int ACCW = BITDEPTH + BITFRACTION;
    localparam int TOP  = ACCW - 1;
    localparam int SUMW = ACCW + 1;
    localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [BITDEPTH-1:0] MAX    = {BITDEPTH{1'b1}};
    localparam logic [BITDEPTH-1:0] MID    = {1'b0, {(BITDEPTH-1){1'b1}}};
    localparam logic [BITDEPTH-1:0] PW_RST = {1'b1, {(BITDEPTH-1){1'b0}}};
    localparam logic [CHW-1:0]      LAST_CH = CHW'(CHANNELS - 1);

    localparam logic [2:0] W_SAW   = 3'd0;
    localparam logic [2:0] W_TRI   = 3'd1;
    localparam logic [2:0] W_PULSE = 3'd2;
    localparam logic [2:0] W_SUB   = 3'd3;
    localparam logic [2:0] W_NOISE = 3'd4;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              r_state;
    logic [CHW-1:0]      r_ch;
    logic [15:0]         r_lfsr;
    logic                r_busy;
    logic [BITDEPTH-1:0] r_out;
    logic [CHW-1:0]      r_out_ch;
    logic                r_out_valid;

    // per-channel state
    logic [ACCW-1:0]     r_acc   [CHANNELS];
    logic [15:0]         r_inc   [CHANNELS];
    logic [2:0]          r_wave  [CHANNELS];
    logic [BITDEPTH-1:0] r_pw    [CHANNELS];
    logic                r_sub   [CHANNELS];
    logic [BITDEPTH-1:0] r_noise [CHANNELS];

    logic                w_run;
    logic [SUMW-1:0]     w_sum;
    logic                w_carry;
    logic                w_hit_rst;
    logic [ACCW-1:0]     w_acc_new;
    logic                w_sub_new;
    logic [BITDEPTH-1:0] w_noise_new;
    logic [BITDEPTH-1:0] w_ph;
    logic [BITDEPTH-1:0] w_tri;
    logic [BITDEPTH-1:0] w_sample;
    logic                w_fb;
    logic [15:0]         w_lfsr_next;

    assign w_run = (r_state == RUN);

    // shared datapath: operate on the channel selected by r_ch
    assign w_sum   = SUMW'(r_acc[r_ch]) + SUMW'(r_inc[r_ch]);
    assign w_carry = w_sum[ACCW];

    // a phase reset aimed at the channel being processed wins over the
    // accumulate, and the sample is produced from the cleared state
    assign w_hit_rst = w_run && bus.cfg_we && bus.cfg_phase_rst && (bus.cfg_ch == r_ch);

    always_comb begin
        w_acc_new   = w_sum[TOP:0];
        w_sub_new   = r_sub[r_ch] ^ w_carry;
        w_noise_new = w_carry ? r_lfsr[15 -: BITDEPTH] : r_noise[r_ch];
        if (w_hit_rst) begin
            w_acc_new   = '0;
            w_sub_new   = 1'b0;
            w_noise_new = '0;
        end
    end

    assign w_ph  = w_acc_new[TOP -: BITDEPTH];
    // fold the half-cycle below the MSB into a rising/falling ramp
    assign w_tri = w_acc_new[TOP] ? ~w_acc_new[TOP-1 -: BITDEPTH]
                                  :  w_acc_new[TOP-1 -: BITDEPTH];

    always_comb begin
        w_sample = MID;
        case (r_wave[r_ch])
            W_SAW:   w_sample = w_ph;
            W_TRI:   w_sample = w_tri;
            W_PULSE: w_sample = (w_ph < r_pw[r_ch]) ? MAX : '0;
            W_SUB:   w_sample = w_sub_new ? MAX : '0;
            W_NOISE: w_sample = w_noise_new;
            default: w_sample = MID;
        endcase
    end

    // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, right-shifting
    assign w_fb        = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_lfsr_next = {w_fb, r_lfsr[15:1]};

    // sequencer and registered outputs
    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_busy      <= 1'b0;
            r_out       <= MID;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_lfsr      <= 16'hACE1;
        end else begin
            r_lfsr      <= w_lfsr_next;
            r_out_valid <= w_run;
            if (w_run) begin
                r_out    <= w_sample;
                r_out_ch <= r_ch;
            end
            if (r_state == IDLE) begin
                if (bus.tick) begin
                    r_state <= RUN;
                    r_ch    <= '0;
                    r_busy  <= 1'b1;
                end
            end else begin
                if (r_ch == LAST_CH) begin
                    r_ch <= '0;
                    // a tick on the last channel chains the next sweep
                    // without a gap; otherwise ticks in RUN are dropped
                    if (!bus.tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end else begin
                    r_ch <= r_ch + 1'b1;
                end
            end
        end
    end

    // per-channel registers; config writes to channels >= CHANNELS match
    // no entry and are dropped
    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_acc[k]   <= '0;
                r_inc[k]   <= '0;
                r_wave[k]  <= W_SAW;
                r_pw[k]    <= PW_RST;
                r_sub[k]   <= 1'b0;
                r_noise[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (bus.cfg_we && (bus.cfg_ch == CHW'(k))) begin
                    r_inc[k]  <= bus.cfg_inc;
                    r_wave[k] <= bus.cfg_wave;
                    r_pw[k]   <= bus.cfg_pw;
                end
                if (w_run && (r_ch == CHW'(k))) begin
                    r_acc[k]   <= w_acc_new;
                    r_sub[k]   <= w_sub_new;
                    r_noise[k] <= w_noise_new;
                end else if (bus.cfg_we && bus.cfg_phase_rst && (bus.cfg_ch == CHW'(k))) begin
                    r_acc[k]   <= '0;
                    r_sub[k]   <= 1'b0;
                    r_noise[k] <= '0;
                end
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out       = r_out;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_osc_bank.sv
// tb_osc_bank
//   Directed bench for osc_bank: a 4-channel instance for the waveform,
//   timing, collision and reset behaviour, and a 3-channel instance for
//   out-of-range config writes.
module tb_osc_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    osc_bank_if #(.BITDEPTH(14), .CHANNELS(4)) bus ();
    osc_bank_if #(.BITDEPTH(14), .CHANNELS(3)) bus3 ();

    osc_bank #(.BITDEPTH(14), .BITFRACTION(6), .CHANNELS(4)) dut (
        .sample_clock(clk), .rst(rst), .bus(bus)
    );
    osc_bank #(.BITDEPTH(14), .BITFRACTION(6), .CHANNELS(3)) dut3 (
        .sample_clock(clk), .rst(rst), .bus(bus3)
    );

    // reference noise source: x^16+x^14+x^13+x^11+1, seed ACE1
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst)
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= (m_lfsr >> 1) | 16'((m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]) << 15);

    int n_vec = 0;
    int n_err = 0;
    logic [13:0] smp [4];
    logic [15:0] m_pre;

    int tri_n [9] = '{1, 2, 16, 31, 32, 33, 48, 63, 64};
    int tri_e [9] = '{512, 1024, 8192, 15872, 16383, 15871, 8191, 511, 0};
    int pul_n [6] = '{1, 15, 16, 31, 32, 33};
    int pul_e [6] = '{16383, 16383, 0, 0, 16383, 16383};
    int sub_n [5] = '{1, 31, 32, 63, 64};
    int sub_e [5] = '{0, 0, 16383, 16383, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] inc, input logic [2:0] wave,
                       input logic [13:0] pw, input logic prst);
        bus.cfg_we = 1'b1; bus.cfg_ch = ch; bus.cfg_inc = inc;
        bus.cfg_wave = wave; bus.cfg_pw = pw; bus.cfg_phase_rst = prst;
        step();
        bus.cfg_we = 1'b0; bus.cfg_phase_rst = 1'b0;
    endtask

    // one full sweep on the 4-channel instance; checks strobe/index/busy timing
    task automatic sweep();
        logic ok;
        ok = 1'b1;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) ok = 1'b0;
        m_pre = m_lfsr;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'(k) || bus.busy !== (k < 3)) ok = 1'b0;
            smp[k] = bus.out;
        end
        check("sweep_seq", 32'(ok), 32'd1);
    endtask

    task automatic sweep3();
        logic ok;
        ok = 1'b1;
        bus3.tick = 1'b1;
        step();
        bus3.tick = 1'b0;
        if (bus3.busy !== 1'b1) ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus3.out_valid !== 1'b1 || bus3.out_ch !== 2'(k) || bus3.busy !== (k < 2)) ok = 1'b0;
            smp[k] = bus3.out;
        end
        step();
        if (bus3.out_valid !== 1'b0 || bus3.busy !== 1'b0) ok = 1'b0;
        check("sweep3_seq", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [13:0] nexp;
        logic ok;
        bus.tick = 0; bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_inc = 0;
        bus.cfg_wave = 0; bus.cfg_pw = 0; bus.cfg_phase_rst = 0;
        bus3.tick = 0; bus3.cfg_we = 0; bus3.cfg_ch = 0; bus3.cfg_inc = 0;
        bus3.cfg_wave = 0; bus3.cfg_pw = 0; bus3.cfg_phase_rst = 0;

        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_out", 32'(bus.out), 32'd8191);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_ch", 32'(bus.out_ch), 32'd0);

        // SAW: 256 per sweep, wraps at sweep 64
        cfg(0, 16'h4000, 3'd0, 14'd8192, 1'b0);
        for (int n = 1; n <= 64; n++) begin
            sweep();
            check("saw_ch0", 32'(smp[0]), 32'((256 * n) % 16384));
            if (n == 1) begin
                check("saw_ch1_idle", 32'(smp[1]), 32'd0);
                check("saw_ch3_idle", 32'(smp[3]), 32'd0);
            end
        end

        // TRI
        cfg(0, 16'h4000, 3'd1, 14'd8192, 1'b1);
        for (int n = 1; n <= 64; n++) begin
            sweep();
            for (int j = 0; j < 9; j++)
                if (n == tri_n[j]) check("tri_ch0", 32'(smp[0]), 32'(tri_e[j]));
        end

        // PULSE, pw = 8192 (ph == pw gives 0)
        cfg(0, 16'h8000, 3'd2, 14'd8192, 1'b1);
        for (int n = 1; n <= 33; n++) begin
            sweep();
            for (int j = 0; j < 6; j++)
                if (n == pul_n[j]) check("pulse_ch0", 32'(smp[0]), 32'(pul_e[j]));
        end

        // SUB: first carry at sweep 32
        cfg(0, 16'h8000, 3'd3, 14'd8192, 1'b1);
        for (int n = 1; n <= 64; n++) begin
            sweep();
            for (int j = 0; j < 5; j++)
                if (n == sub_n[j]) check("sub_ch0", 32'(smp[0]), 32'(sub_e[j]));
        end

        // NOISE: holds 0 until first carry, then latches LFSR top bits per carry
        cfg(0, 16'h8000, 3'd4, 14'd8192, 1'b1);
        nexp = '0;
        for (int n = 1; n <= 64; n++) begin
            sweep();
            if (n == 32 || n == 64) nexp = m_pre[15:2];
            check("noise_ch0", 32'(smp[0]), 32'(nexp));
        end

        // config collision on ch1, plus a tick while busy
        cfg(1, 16'h1000, 3'd0, 14'd8192, 1'b0);
        sweep();
        check("coll_pre_ch1", 32'(smp[1]), 32'd64);
        bus.tick = 1'b1;
        step();
        step();
        bus.tick = 1'b0;
        check("coll_ch0_valid", 32'({bus.out_valid, bus.out_ch}), 32'({1'b1, 2'd0}));
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_inc = 16'h4000;
        bus.cfg_wave = 3'd0; bus.cfg_pw = 14'd8192; bus.cfg_phase_rst = 1'b1;
        step();
        bus.cfg_we = 1'b0; bus.cfg_phase_rst = 1'b0;
        check("coll_ch1_idx", 32'({bus.out_valid, bus.out_ch}), 32'({1'b1, 2'd1}));
        check("coll_ch1_out", 32'(bus.out), 32'd0);
        step();
        step();
        check("coll_busy_end", 32'(bus.busy), 32'd0);
        step();
        check("tick_ignored", 32'({bus.busy, bus.out_valid}), 32'd0);
        sweep();
        check("coll_next_ch1", 32'(smp[1]), 32'd256);

        // back-to-back: tick held through three sweeps
        bus.tick = 1'b1;
        step();
        ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 11) bus.tick = 1'b0;
            step();
            if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'(k % 4)) ok = 1'b0;
            if (k == 1) check("b2b_ch1_a", 32'(bus.out), 32'd512);
            if (k == 5) check("b2b_ch1_b", 32'(bus.out), 32'd768);
            if (k == 9) check("b2b_ch1_c", 32'(bus.out), 32'd1024);
        end
        check("b2b_stream", 32'(ok), 32'd1);
        check("b2b_busy_end", 32'(bus.busy), 32'd0);
        step();
        check("b2b_stop", 32'(bus.out_valid), 32'd0);

        // async reset mid-sweep while ch2 is being processed
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
        step();
        check("pre_rst_ch1", 32'(bus.out), 32'd1280);
        #2 rst = 1'b1;
        #1;
        check("arst_out", 32'(bus.out), 32'd8191);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        #1 rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
        end
        check("arst_no_strobe", 32'(ok), 32'd1);

        // 3-channel instance: writes to channel 3 are dropped
        bus3.cfg_we = 1'b1; bus3.cfg_ch = 2'd0; bus3.cfg_inc = 16'h4000;
        bus3.cfg_wave = 3'd0; bus3.cfg_pw = 14'd8192; bus3.cfg_phase_rst = 1'b0;
        step();
        bus3.cfg_ch = 2'd3; bus3.cfg_inc = 16'hFFFF; bus3.cfg_wave = 3'd3;
        bus3.cfg_pw = 14'd0; bus3.cfg_phase_rst = 1'b1;
        step();
        bus3.cfg_we = 1'b0; bus3.cfg_phase_rst = 1'b0;
        sweep3();
        check("c3_ch0", 32'(smp[0]), 32'd256);
        check("c3_ch1", 32'(smp[1]), 32'd0);
        check("c3_ch2", 32'(smp[2]), 32'd0);
        bus3.cfg_we = 1'b1; bus3.cfg_ch = 2'd3; bus3.cfg_phase_rst = 1'b1;
        step();
        bus3.cfg_we = 1'b0; bus3.cfg_phase_rst = 1'b0;
        sweep3();
        check("c3_ch0_b", 32'(smp[0]), 32'd512);
        check("c3_ch2_b", 32'(smp[2]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/osc_bank.md
# osc_bank

Time-multiplexed, parametrised bank of `CHANNELS` phase-accumulator oscillators for the audio subsystem. One shared datapath advances each channel's accumulator once per sample tick. Each channel has run-time selectable waveform (saw, triangle, variable-width pulse, sub-octave square, noise), a 16-bit increment, a pulse width and a phase reset. Results stream out one channel per clock with a valid strobe and channel index, to feed the downstream mixer.

## Interface
- `BITDEPTH`, 14, output sample width; legal range 4..16.
- `BITFRACTION`, 6, extra accumulator fraction bits; accumulator width `ACCW = BITDEPTH+BITFRACTION`, `TOP = ACCW-1`.
- `CHANNELS`, 4, number of oscillators, ≥1; `CHW = max(1, clog2(CHANNELS))`.
- `sample_clock`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  start one sweep over all channels; honoured only while `busy`=0.
- `cfg_we`  in  1  write strobe for channel `cfg_ch`.
- `cfg_ch`  in  CHW  target channel; writes to channels ≥ CHANNELS are ignored.
- `cfg_inc`  in  16  phase increment, zero-extended to ACCW.
- `cfg_wave`  in  3  0 SAW, 1 TRI, 2 PULSE, 3 SUB, 4 NOISE, 5–7 silent.
- `cfg_pw`  in  BITDEPTH  pulse threshold.
- `cfg_phase_rst`  in  1  with `cfg_we`, clears the channel's accumulator, sub bit and noise hold.
- `busy`  out  1  sweep in progress.
- `out`  out  BITDEPTH  unsigned sample; `MAX = 2^BITDEPTH-1`, `MID = 2^(BITDEPTH-1)-1`.
- `out_ch`  out  CHW  channel of `out`.
- `out_valid`  out  1  one-cycle strobe per channel result.

## Operation
- FSM has 2 states, IDLE and RUN, plus a channel counter `ch`.
  - IDLE + `tick`: go to RUN with `ch`=0.
  - RUN: process channel `ch`. `ch` increments each cycle. After `CHANNELS-1` it returns to IDLE.
  - `tick` in RUN is ignored, not queued.
- Per processed channel: `{carry, acc'} = acc + inc`, modulo 2^ACCW. Let `ph = acc'[TOP -: BITDEPTH]`.
  - On `carry`: toggle `sub` and latch `noise_hold = lfsr[15 -: BITDEPTH]`.
- Waveform from the updated state:
  - SAW: `ph`.
  - TRI: `acc'[TOP] ? ~acc'[TOP-1 -: BITDEPTH] : acc'[TOP-1 -: BITDEPTH]`.
  - PULSE: `ph < pw ? MAX : 0`.
  - SUB: `sub' ? MAX : 0`, a square wave at half the oscillator frequency.
  - NOISE: `noise_hold'`.
  - 5–7: `MID`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Reset value 16'hACE1. Steps every clock regardless of state. Never reaches all-zero.
- Config write lands at the clock edge. If it targets the channel being processed in that same cycle:
  - Processing uses the pre-write inc/wave/pw.
  - `cfg_phase_rst` overrides the accumulate: acc, sub and noise_hold all become 0. That channel's output this sweep is computed from acc'=0.
- Reset values:
  - acc, inc, sub, noise_hold: 0.
  - wave: SAW.
  - pw: 2^(BITDEPTH-1).
  - out: MID. out_ch: 0. out_valid: 0. busy: 0.
  - FSM: IDLE. lfsr: 16'hACE1.
- Reset mid-sweep aborts the sweep immediately. No further `out_valid` pulses until the next `tick`.

## Timing
- `tick` sampled high at edge t (IDLE) → `busy`=1 after edges t … t+CHANNELS-1, and 0 after edge t+CHANNELS.
- Channel k result is registered at edge t+1+k. `out_valid`=1, `out_ch`=k for exactly that one cycle.
- Latency from `tick` edge to channel 0 valid is 1 cycle. A full sweep is CHANNELS cycles.
- The earliest next `tick` is accepted at edge t+CHANNELS, which gives a back-to-back sweep with no gap in `out_valid`.
- `out` holds its last value when `out_valid`=0.

## Test plan
- Reset: assert `rst` asynchronously between edges → outputs go immediately to `out`=MID (8191), `busy`=0, `out_valid`=0. Also assert mid-sweep on ch 2 → no ch 3 strobe.
- SAW, ch0, inc=16'h4000, defaults 14/6/4: sweep n gives `out`=(256·n) mod 16384. It wraps to 0 at sweep 64. `out_ch` sequence is 0,1,2,3 on 4 consecutive cycles. `busy` is high for 4 cycles.
- TRI inc=16'h4000 → 512, 1024 … rising to 16383-ish at sweep 32, then falling symmetric. PULSE inc=16'h8000, pw=8192 → 16383 for sweeps 1–15, 0 for sweeps 16–31, repeating.
- SUB inc=16'h8000 → 0 for sweeps 1–31, 16383 from sweep 32 (first carry) to 63, toggling every 32 sweeps. NOISE value is constant between carries and changes only at carry sweeps.
- Config collision: write inc and `cfg_phase_rst` to ch1 in the same cycle ch1 is processed → that result is 0 (SAW). The next sweep uses the new inc. `tick` pulses while `busy` → ignored, sweep count unchanged.
- Back-to-back: `tick` at each edge where `busy` falls → continuous `out_valid` stream cycling 0..3. Writes with `cfg_ch` ≥ CHANNELS (CHANNELS=3) alter nothing.
